op_dispatcher: RTL
==================

// Module: op_dispatcher
// PURPOSE
//  Upstream/downstream wrapper for the control/datapath pair. Buffers
//  operands arriving on a valid/ready port in a small FIFO and presents one
//  operand at a time on x_out. Drives start to the control unit, waits for
//  pronto, captures the datapath result, and returns it on a valid/ready
//  output port. Watchdog flags a control unit that never answers.
// PARAMETERS
//  WIDTH    8   operand/result width in bits
//  DEPTH    4   operand FIFO entries (power of two, >=2)
//  TIMEOUT  64  max cycles in ISSUE waiting for pronto before abort (>=2)
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst          in   1      synchronous reset, active-low (rst==0 resets on posedge clk)
//  in_valid     in   1      operand valid
//  in_ready     out  1      FIFO not full
//  in_data      in   WIDTH  operand
//  x_out        out  WIDTH  operand to datapath, stable from ISSUE entry to GAP exit
//  start        out  1      request to control unit
//  pronto       in   1      control unit done
//  res_in       in   WIDTH  datapath result, valid in the cycle pronto==1
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  out_data     out  WIDTH  captured result
//  busy         out  1      FSM != IDLE or FIFO not empty
//  timeout_err  out  1      sticky; set on watchdog abort, cleared only by reset
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0, state IDLE; start=0, out_valid=0,
//   out_data=0, x_out=0, timeout_err=0, in_ready=1, busy=0.
//  FIFO push on in_valid&in_ready. Pop only on IDLE->ISSUE. Push when full is
//   impossible (in_ready=0). Push and pop in the same cycle are both honoured;
//   the count is unchanged. Pointers wrap modulo DEPTH; count is
//   $clog2(DEPTH)+1 bits wide.
//  FSM states:
//   IDLE    start=0. If FIFO non-empty: pop head into x_out, go to ISSUE next
//           cycle. A push into an empty FIFO is first visible one cycle later.
//   ISSUE   start=1; watchdog counts cycles spent in ISSUE.
//           If pronto=1: register res_in into out_data, go to HOLD.
//           Else if the watchdog count reaches TIMEOUT-1: set timeout_err,
//           drop the operand, go to GAP.
//   HOLD    start=0, out_valid=1, out_data stable. If out_ready=1: go to GAP.
//           out_valid may stay high indefinitely.
//   GAP     start=0 for exactly one cycle so the control unit returns to
//           idle, then go to IDLE.
//  Minimum operand-to-operand spacing is 4 cycles (IDLE, ISSUE, HOLD, GAP)
//   when pronto and out_ready are immediate.
//  pronto is ignored outside ISSUE. A pronto in the same cycle as the
//   timeout edge wins: the result is captured and no error is flagged.
//  Results are never reordered or dropped, except the aborted operand.
//  Reset mid-operation: state, FIFO contents and outputs return to reset
//   values on that edge; a pending result is lost.
//  All state updates are registered; only in_ready and busy are
//   combinational from registered state.
// TESTING
//  1 Reset with rst=0 for 2 cycles, then push 8'h2A; pronto returns in the
//    3rd ISSUE cycle with res_in=8'h15, out_ready=1 -> start high exactly
//    3 cycles; out_data=8'h15; out_valid high 1 cycle.
//  2 Push 5 operands back-to-back with DEPTH=4 while the FSM is stalled
//    -> in_ready=0 after the 4th push; the 5th is held by the source; all 5
//    results come out in order.
//  3 Never assert pronto, TIMEOUT=64 -> start high exactly 64 cycles,
//    timeout_err=1 (sticky), the next queued operand is then issued.
//  4 Hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_data are
//    stable and start=0; the next operand is not issued until 2 cycles after
//    out_ready rises.
//  5 Assert rst=0 during ISSUE with 2 operands queued -> next cycle start=0,
//    FIFO empty, busy=0, timeout_err=0.
//  6 Push and pop in the same cycle with 1 entry queued -> count stays 1;
//    wrap-around over 3*DEPTH operands keeps correct data order.

Source files
------------

// File: rtl/op_dispatcher.sv
// op_dispatcher: buffers incoming operands in a small FIFO and hands them one
// at a time to an external control/datapath pair. Each operand runs through
// IDLE -> ISSUE -> HOLD -> GAP. The result captured on pronto is returned on a
// valid/ready output port. A watchdog aborts an ISSUE that never sees pronto.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. in_ready and busy are the only combinational outputs, and
// they depend on registered state alone. out_valid stays high, with out_data
// held, until out_ready is seen.
module op_dispatcher #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] x_out,
    output logic             start,
    input  logic             pronto,
    input  logic [WIDTH-1:0] res_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [TW-1:0]    r_wd;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != FULL_COUNT);
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign w_push   = in_valid && in_ready;
    // The head is consumed only when the FSM leaves IDLE to issue it.
    assign w_pop    = (r_state == S_IDLE) && !w_empty;

    // Operand FIFO: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Dispatch FSM with registered start/out_valid/out_data/x_out and watchdog.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            x_out       <= '0;
            start       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        x_out   <= r_mem[r_rd_ptr];
                        start   <= 1'b1;
                        r_wd    <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // pronto on the last watchdog cycle still wins.
                    if (pronto) begin
                        out_data  <= res_in;
                        out_valid <= 1'b1;
                        start     <= 1'b0;
                        r_state   <= S_HOLD;
                    end else if (r_wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        start       <= 1'b0;
                        r_state     <= S_GAP;
                    end else begin
                        r_wd <= r_wd + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_GAP;
                    end
                end
                default: begin
                    // One cycle with start low lets the control unit re-arm.
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
